// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
package bcd_pkg;

    localparam int BIN_W = 8;
    localparam int BCD_W = 12;

    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// rtl/bcd_dabble_step.sv - one double-dabble step: add 3 to digits >= 5, then shift in a bit
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             ser_in,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_in[4*i +: 4] >= ADD3_THRESH) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
        bcd_out = {adj[BCD_W-2:0], ser_in};
    end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// rtl/bcd_conv_ctrl.sv - handshaked 8-bit binary to 3-digit BCD converter, one bit per cycle
module bcd_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int PRELOAD = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [BCD_W-1:0] out_bcd,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] res_q, res_d;
    logic [BIN_W-1:0] opnd_q, opnd_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [2:0]       bit_idx;
    logic [BCD_W-1:0] step_out;

    // Counter value n selects operand bit n-1, so the operand never needs shifting.
    assign bit_idx = 3'(cnt_q - 4'd1);

    bcd_dabble_step u_step (
        .bcd_in  (bcd_q),
        .ser_in  (opnd_q[bit_idx]),
        .bcd_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        res_d   = res_q;
        opnd_d  = opnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    bcd_d   = BCD_W'(in_data[BIN_W-1 -: PRELOAD]);
                    cnt_d   = 4'(BIN_W - PRELOAD);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = step_out;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = step_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bcd_q       <= '0;
            res_q       <= '0;
            opnd_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            res_q       <= res_d;
            opnd_q      <= opnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb/tb_bcd_conv_ctrl.sv - self-checking bench for bcd_conv_ctrl
module tb_bcd_conv_ctrl;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_bcd;
    logic        out_ready;
    logic        busy;

    logic        in_valid2;
    logic [7:0]  in_data2;
    logic        in_ready2;
    logic        out_valid2;
    logic [11:0] out_bcd2;
    logic        out_ready2;
    logic        busy2;

    int n_cmp = 0;
    int n_bad = 0;

    bit started  = 0;
    bit rand_rdy = 0;

    bcd_conv_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_bcd(out_bcd),
        .out_ready(out_ready), .busy(busy)
    );

    bcd_conv_ctrl #(.PRELOAD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_bcd(out_bcd2),
        .out_ready(out_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dec(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: idle -> LAT cycles converting -> result held until taken.
    int m_phase  = 0;
    int m_remain = 0;
    int m_val    = 0;
    int cyc      = 0;
    int last_acc = -1000;

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            chk1("m_in_ready", in_ready, m_phase == 0);
            chk1("m_out_valid", out_valid, m_phase == 2);
            chk1("m_busy", busy, m_phase != 0);
            chk("m_out_bcd", out_bcd, (m_phase == 2) ? dec(m_val) : 12'h000);
            if (!reset_n) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (in_valid) begin
                    chk1("accept_spacing", (cyc - last_acc) >= 7, 1'b1);
                    last_acc = cyc;
                    m_val    = int'(in_data);
                    m_remain = LAT;
                    m_phase  = 1;
                end
            end else if (m_phase == 1) begin
                m_remain--;
                if (m_remain == 0) m_phase = 2;
            end else if (out_ready) begin
                m_phase = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [7:0] v);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk1("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_hs();
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = out_valid && out_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk1("handshake_timeout", 1'b0, 1'b1);
    endtask

    task automatic lat_check(input logic [7:0] v, input logic [11:0] exp);
        int n;
        n = 0;
        send(v);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk("latency", 12'(n), 12'd5);
        chk("lit_bcd", out_bcd, exp);
        wait_hs();
    endtask

    initial begin
        int n;
        logic [7:0]  lit_in  [3];
        logic [11:0] lit_out [3];
        lit_in  = '{8'd255, 8'd0, 8'd99};
        lit_out = '{12'h255, 12'h000, 12'h099};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = 8'h00;
        out_ready2 = 1'b1;
        @(posedge clk);
        started = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_bcd", out_bcd, 12'h000);
        chk1("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        chk("model_dec_255", dec(255), 12'h255);
        chk("model_dec_128", dec(128), 12'h128);

        // PRELOAD=1 instance: seven steps
        in_valid2 = 1'b1;
        in_data2  = 8'd200;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid2 && n < 20);
        chk("p1_latency", 12'(n), 12'd7);
        chk("p1_bcd", out_bcd2, 12'h200);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) lat_check(lit_in[i], lit_out[i]);

        // Consumer stalls with a result held
        out_ready = 1'b0;
        send(8'd128);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("stall_valid", out_valid, 1'b1);
            chk("stall_bcd", out_bcd, 12'h128);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_hs();

        // Reset during the third shift cycle
        send(8'd77);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk1("abort_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("abort_no_valid", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Exhaustive sweep with random consumer stalls
        rand_rdy = 1;
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            wait_hs();
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_conv_ctrl.md
BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

Interface
REQ-001 SHALL have parameter PRELOAD, default 3: number of input MSBs loaded directly as the initial BCD units digit; legal range 1..3.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: requester offers a binary operand.
REQ-005 SHALL have port in_data, input, 8: unsigned binary operand, 0..255.
REQ-006 SHALL have port in_ready, output, 1: block will accept an operand this cycle.
REQ-007 SHALL have port out_valid, output, 1: out_bcd holds a completed result.
REQ-008 SHALL have port out_bcd, output, 12: three BCD digits {hundreds, tens, units}.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result this cycle.
REQ-010 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-011 SHALL implement an FSM with three states: IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready high only in IDLE.
REQ-013 SHALL drive out_valid high only in DONE.
REQ-014 On in_valid && in_ready: capture in_data; load the BCD register with {zeros, in_data[7:8-PRELOAD]}; set step counter = 8-PRELOAD; go to SHIFT.
REQ-015 Each SHIFT cycle: add 3 to every BCD nibble >= 5, then shift left one bit, inserting the next unconsumed operand bit (MSB first) at bit 0; decrement the counter.
REQ-016 The step producing counter 0 SHALL write the final result and move to DONE at the same edge.
REQ-017 Latency, handshake edge to out_valid high: exactly 8-PRELOAD cycles (5 at default).
REQ-018 In DONE, out_bcd and out_valid SHALL hold stable until out_ready is sampled high.
REQ-019 On out_valid && out_ready: return to IDLE.
REQ-020 in_ready SHALL NOT rise in the same cycle as the out_ready handshake; no bypass. Minimum spacing between accepts is 7 cycles at default.
REQ-021 in_valid and in_data SHALL be ignored outside IDLE; no queuing.
REQ-022 out_bcd SHALL read 0 whenever out_valid is low.
REQ-023 Every result SHALL equal the exact decimal value of the operand; no digit exceeds 9.
REQ-024 No illegal-state lockup: any unencoded state value SHALL return to IDLE on the next edge.

Reset
REQ-025 While reset_n is low at a clock edge: state = IDLE, counter = 0, BCD register = 0, captured operand = 0.
REQ-026 Reset outputs: in_ready = 1, out_valid = 0, out_bcd = 0, busy = 0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort and discard the conversion, with no out_valid pulse afterward.
REQ-028 Reset SHALL dominate a simultaneous in or out handshake.

Structure
REQ-029 Package bcd_pkg SHALL hold the state enum, BIN_W = 8, BCD_W = 12, and the add-3 threshold constant 5.
REQ-030 The per-step correct-and-shift logic SHALL be one combinational sub-module, bcd_dabble_step (12-bit BCD in, 1-bit serial in, 12-bit BCD out), instantiated once and reused every SHIFT cycle.
REQ-031 Target size: 120-400 RTL lines; no simulation display statements in synthesizable code.

Verification
REQ-032 in_data = 255 accepted at cycle 0 -> out_valid rises after cycle 5 edge, out_bcd = 12'h255.
REQ-033 in_data = 0 and in_data = 99 -> out_bcd = 12'h000 and 12'h099 respectively, each at 5-cycle latency.
REQ-034 Result 12'h128 with out_ready low for 10 cycles -> out_valid and out_bcd stable throughout; in_ready stays 0; a new in_valid is ignored.
REQ-035 reset_n low for one edge during the 3rd SHIFT cycle -> next cycle IDLE, in_ready = 1, out_valid never asserts for the aborted operand.
REQ-036 Exhaustive sweep 0..255 with random out_ready stalls -> every out_bcd matches a decimal model; accept spacing >= 7 cycles.
REQ-037 PRELOAD = 1 build, in_data = 200 -> out_bcd = 12'h200 after exactly 7 cycles.
